// File: rtl/dinter_alu_pkg.sv
// Shared widths, opcode encoding and flag bundle for the dinter_alu datapath.
package dinter_alu_pkg;

    localparam int N_DEF = 8;
    localparam int M_DEF = 16;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_AND = 3'd3,
        OP_OR  = 3'd4,
        OP_XOR = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic zero;
        logic carry;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/dinter_alu_if.sv
// Operand/result bundle between a controller (master) and the ALU (slave).
interface dinter_alu_if #(
    parameter int N = 8,
    parameter int M = 16
);
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   sel;
    logic [M-1:0] out;
    logic         out_valid;
    logic         zero;
    logic         carry;
    logic         overflow;

    modport master (
        output in_valid, a, b, sel,
        input  out, out_valid, zero, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, sel,
        output out, out_valid, zero, carry, overflow
    );
endinterface

// File: rtl/dinter_alu_core.sv
// Purely combinational 8-operation ALU: M-bit zero-extended result plus flags.
module dinter_alu_core
    import dinter_alu_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic [2:0]   sel_i,
    output logic [M-1:0] result_o,
    output alu_flags_t   flags_o
);

    logic [N:0]   sum;
    logic [M-1:0] a_ext;
    logic [M-1:0] b_ext;
    logic [M-1:0] diff;
    logic [31:0]  shamt;

    assign a_ext = M'(a_i);
    assign b_ext = M'(b_i);
    assign sum   = {1'b0, a_i} + {1'b0, b_i};
    assign diff  = a_ext - b_ext;
    assign shamt = 32'(b_i);

    always_comb begin
        // ADD is the baseline so any unlisted code behaves as ADD.
        result_o         = M'(sum);
        flags_o.carry    = sum[N];
        flags_o.overflow = (a_i[N-1] == b_i[N-1]) && (sum[N-1] != a_i[N-1]);
        case (alu_op_e'(sel_i))
            OP_SUB: begin
                result_o         = diff;
                flags_o.carry    = (a_i < b_i);
                flags_o.overflow = (a_i[N-1] != b_i[N-1]) && (diff[N-1] != a_i[N-1]);
            end
            OP_MUL: begin
                result_o         = a_ext * b_ext;
                flags_o.carry    = 1'b0;
                flags_o.overflow = 1'b0;
            end
            OP_AND, OP_OR, OP_XOR: begin
                result_o = (sel_i == OP_AND) ? M'(a_i & b_i) :
                           (sel_i == OP_OR)  ? M'(a_i | b_i) : M'(a_i ^ b_i);
                flags_o.carry    = 1'b0;
                flags_o.overflow = 1'b0;
            end
            OP_SHL: begin
                result_o = a_ext << shamt;
                // Bits of a that land at or above bit M are the ones lost.
                if (shamt >= 32'(M)) flags_o.carry = |a_i;
                else                 flags_o.carry = |(a_ext >> (32'(M) - shamt));
                flags_o.overflow = 1'b0;
            end
            OP_SHR: begin
                result_o         = M'(a_i >> shamt);
                flags_o.carry    = 1'b0;
                flags_o.overflow = 1'b0;
            end
            default: ;
        endcase
        flags_o.zero = (result_o == '0);
    end

endmodule

// File: rtl/dinter_alu.sv
// Registered ALU wrapper: one-cycle latency, results and flags hold while idle.
module dinter_alu
    import dinter_alu_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
) (
    input  logic         clk,
    input  logic         rst,
    dinter_alu_if.slave  bus
);

    if (M < 2 * N) begin : g_bad_width
        $error("dinter_alu: M must be at least 2*N");
    end
    if (N < 2) begin : g_bad_n
        $error("dinter_alu: N must be at least 2");
    end

    logic [M-1:0] core_result;
    alu_flags_t   core_flags;

    logic [M-1:0] out_q,   out_d;
    alu_flags_t   flags_q, flags_d;
    logic         valid_q, valid_d;

    dinter_alu_core #(.N(N), .M(M)) u_core (
        .a_i      (bus.a),
        .b_i      (bus.b),
        .sel_i    (bus.sel),
        .result_o (core_result),
        .flags_o  (core_flags)
    );

    always_comb begin
        valid_d = bus.in_valid;
        out_d   = bus.in_valid ? core_result : out_q;
        flags_d = bus.in_valid ? core_flags  : flags_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;
    assign bus.zero      = flags_q.zero;
    assign bus.carry     = flags_q.carry;
    assign bus.overflow  = flags_q.overflow;

endmodule

// File: tb/tb_dinter_alu.sv
// Directed and random checks of dinter_alu against an arithmetic reference model.
module tb_dinter_alu;

    localparam int N   = 8;
    localparam int M   = 16;
    localparam int MOD = 1 << M;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    int   exp_out;
    bit   exp_valid, exp_z, exp_c, exp_v;

    dinter_alu_if #(.N(N), .M(M)) bus ();

    dinter_alu #(.N(N), .M(M)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " out"},       32'(bus.out),       32'(exp_out));
        chk({tag, " out_valid"}, 32'(bus.out_valid), 32'(exp_valid));
        chk({tag, " zero"},      32'(bus.zero),      32'(exp_z));
        chk({tag, " carry"},     32'(bus.carry),     32'(exp_c));
        chk({tag, " overflow"},  32'(bus.overflow),  32'(exp_v));
    endtask

    function automatic int sview(input int u);
        return (u >= (1 << (N - 1))) ? u - (1 << N) : u;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic ref_model(input int ua, input int ub, input int op,
                             output int r, output bit c, output bit v);
        longint full;
        int     s;
        c = 1'b0;
        v = 1'b0;
        case (op)
            0: begin
                r = ua + ub;
                c = (r >= (1 << N));
                s = sview(ua) + sview(ub);
                v = (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
            end
            1: begin
                r = (ua - ub + MOD) % MOD;
                c = (ua < ub);
                s = sview(ua) - sview(ub);
                v = (s > (1 << (N - 1)) - 1) || (s < -(1 << (N - 1)));
            end
            2: r = ua * ub;
            3: r = ua & ub;
            4: r = ua | ub;
            5: r = ua ^ ub;
            6: begin
                if (ub >= M) begin
                    r = 0;
                    c = (ua != 0);
                end else begin
                    full = longint'(ua) * (longint'(1) << ub);
                    r    = int'(full % MOD);
                    c    = (full >= MOD);
                end
            end
            default: r = (ub >= N) ? 0 : (ua >> ub);
        endcase
    endtask

    task automatic step(input bit v, input int ta, input int tb_, input int ts, input string tag);
        int r;
        bit c, o;
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = ta[N-1:0];
        bus.b        = tb_[N-1:0];
        bus.sel      = ts[2:0];
        exp_valid    = v;
        if (v) begin
            ref_model(ta, tb_, ts, r, c, o);
            exp_out = r;
            exp_c   = c;
            exp_v   = o;
            exp_z   = (r == 0);
        end
        @(posedge clk);
        #1;
        $display("%s: v=%0d a=%02h b=%02h sel=%0d -> out=%04h vld=%0d z=%0d c=%0d o=%0d",
                 tag, v, ta[N-1:0], tb_[N-1:0], ts, bus.out, bus.out_valid,
                 bus.zero, bus.carry, bus.overflow);
        check_all(tag);
    endtask

    task automatic clear_expect();
        exp_out   = 0;
        exp_valid = 1'b0;
        exp_z     = 1'b0;
        exp_c     = 1'b0;
        exp_v     = 1'b0;
    endtask

    initial begin
        int ra, rb, rs;
        bit rv;
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.sel      = '0;
        clear_expect();
        #1;
        check_all("reset");

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        step(1, 8'h0A, 8'h02, 0, "add_small");
        step(1, 8'hFF, 8'h01, 0, "add_carry");
        step(1, 8'h7F, 8'h01, 0, "add_ovf");
        step(1, 8'h0B, 8'h03, 1, "sub_pos");
        step(1, 8'h02, 8'h05, 1, "sub_borrow");
        step(1, 8'h80, 8'h01, 1, "sub_ovf");
        step(1, 8'hFF, 8'hFF, 2, "mul_max");
        step(1, 8'hF0, 8'h3C, 3, "and");
        step(1, 8'hF0, 8'h3C, 4, "or");
        step(1, 8'hF0, 8'h3C, 5, "xor");
        step(1, 8'h0F, 8'hF0, 3, "and_zero");
        step(1, 8'h81, 3,     6, "shl_3");
        step(1, 8'h81, 9,     6, "shl_9");
        step(1, 8'h81, 20,    6, "shl_20");
        step(1, 8'h81, 3,     7, "shr_3");
        step(1, 8'h81, 8,     7, "shr_8");

        step(1, 1, 1, 0, "b2b_1");
        step(1, 2, 2, 0, "b2b_2");
        step(1, 3, 3, 0, "b2b_3");
        step(0, 8'h55, 8'hAA, 2, "idle_hold");
        step(0, 8'h00, 8'h00, 1, "idle_hold2");

        // Async reset between edges must clear outputs without a clock.
        step(1, 5, 5, 0, "pre_rst");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        clear_expect();
        check_all("async_rst");
        bus.in_valid = 1'b1;
        bus.a        = 8'd7;
        bus.b        = 8'd7;
        bus.sel      = 3'd0;
        @(posedge clk);
        #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        step(1, 9, 9, 0, "post_rst");

        for (int i = 0; i < 300; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = int'($urandom_range(0, 255));
            rb = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20))
                                             : int'($urandom_range(0, 255));
            rs = int'($urandom_range(0, 7));
            step(rv, ra, rb, rs, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
